// File: rtl/gate_truth_table_driver.sv
// gate_truth_table_driver
// Drives a small gate through every input pattern in ascending order. Each
// pattern is held for SETTLE cycles, then the gate output is captured for one
// cycle. The captured truth table is compared against an expected table that
// is latched when the sweep starts.
module gate_truth_table_driver #(
    parameter int N_IN   = 2,
    parameter int SETTLE = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [(1<<N_IN)-1:0]  expected,
    input  logic                  gate_out,
    output logic [N_IN-1:0]       drv,
    output logic                  busy,
    output logic                  done,
    output logic                  pass,
    output logic [(1<<N_IN)-1:0]  tt,
    output logic [N_IN:0]         mism
);

    localparam int TT_W  = 1 << N_IN;
    localparam int CNT_W = (SETTLE > 1) ? $clog2(SETTLE) : 1;

    localparam logic [N_IN-1:0]  DRV_LAST = '1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SETTLE - 1);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_SETTLE  = 2'd1,
        S_CAPTURE = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [N_IN-1:0]    drv_q, drv_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               pass_q, pass_d;
    logic [TT_W-1:0]    tt_q, tt_d;
    logic [N_IN:0]      mism_q, mism_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [TT_W-1:0]    exp_q, exp_d;

    // Running mismatch count including the pattern being captured now; the
    // final pass flag must account for the last comparison too.
    logic [N_IN:0]      mism_inc;
    assign mism_inc = mism_q + (N_IN+1)'(gate_out != exp_q[drv_q]);

    // State and output registers, cleared asynchronously.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            drv_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            pass_q  <= 1'b0;
            tt_q    <= '0;
            mism_q  <= '0;
            cnt_q   <= '0;
            exp_q   <= '0;
        end else begin
            state_q <= state_d;
            drv_q   <= drv_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            pass_q  <= pass_d;
            tt_q    <= tt_d;
            mism_q  <= mism_d;
            cnt_q   <= cnt_d;
            exp_q   <= exp_d;
        end
    end

    // Next-state logic: sweep sequencing, capture and result evaluation.
    always_comb begin
        state_d = state_q;
        drv_d   = drv_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        pass_d  = pass_q;
        tt_d    = tt_q;
        mism_d  = mism_q;
        cnt_d   = cnt_q;
        exp_d   = exp_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    drv_d   = '0;
                    tt_d    = '0;
                    mism_d  = '0;
                    cnt_d   = '0;
                    exp_d   = expected;
                    busy_d  = 1'b1;
                    pass_d  = 1'b0;
                    state_d = S_SETTLE;
                end
            end
            S_SETTLE: begin
                if (cnt_q == CNT_LAST) begin
                    cnt_d   = '0;
                    state_d = S_CAPTURE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_CAPTURE: begin
                tt_d[drv_q] = gate_out;
                mism_d      = mism_inc;
                if (drv_q == DRV_LAST) begin
                    // Last pattern: drv stays all-ones until the next start.
                    state_d = S_IDLE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    pass_d  = (mism_inc == '0);
                end else begin
                    drv_d   = drv_q + N_IN'(1);
                    state_d = S_SETTLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign drv  = drv_q;
    assign busy = busy_q;
    assign done = done_q;
    assign pass = pass_q;
    assign tt   = tt_q;
    assign mism = mism_q;

endmodule

// File: doc/gate_truth_table_driver.md
Name: gate_truth_table_driver

Overview:
Sequential stimulus-and-capture stage that sits upstream of a 2-input gate instance (andGate, orGate, or the combined AND&OR network) and consumes that gate's output.
- Steps the gate inputs through every input combination in ascending binary order.
- Waits a fixed settle time per pattern, then samples the gate output.
- Assembles the captured truth table and compares it against an expected table.
- Replaces hand-written delay/$display stimulus with a synthesizable, self-checking driver.

Parameters:
- N_IN, default 2: number of gate inputs driven; the table holds 2**N_IN entries.
- SETTLE, default 2: cycles the inputs are held before sampling; legal range >= 1.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  request a sweep; sampled only in IDLE.
- expected  input  2**N_IN  expected truth table; bit k = expected gate output for input pattern k; latched at start.
- gate_out  input  1  output of the gate under drive; treated as synchronous to clk.
- drv  output  N_IN  gate inputs; drv[N_IN-1] is the MSB. For N_IN=2: a = drv[1], b = drv[0].
- busy  output  1  high while a sweep is in progress.
- done  output  1  one-cycle pulse on completion.
- pass  output  1  1 when the captured table equals expected; held until the next start.
- tt  output  2**N_IN  captured truth table; bit k = gate_out sampled for pattern k.
- mism  output  N_IN+1  count of mismatching entries for the last sweep.

Behaviour:
- Reset (async, while rst=1): state=IDLE; drv=0; busy=0; done=0; pass=0; tt=0; mism=0; settle counter=0; latched expected=0.
- All outputs are registered.
- State IDLE:
  - When start=1 at an edge: drv<=0, tt<=0, mism<=0, cnt<=0, latch expected, busy<=1, pass<=0, go to SETTLE.
  - Otherwise hold all outputs.
- State SETTLE:
  - cnt increments each edge.
  - When cnt==SETTLE-1: cnt<=0, go to CAPTURE.
  - Occupies exactly SETTLE cycles.
- State CAPTURE (1 cycle), at its closing edge:
  - tt[drv]<=gate_out.
  - mism<=mism+(gate_out != exp_latched[drv]).
  - If drv != 2**N_IN-1: drv<=drv+1, go to SETTLE.
  - If drv == 2**N_IN-1 (last pattern): go to IDLE; busy<=0; done<=1 for exactly one cycle; pass<=(final mism==0). The final mism includes the current comparison. drv stays at the all-ones pattern.
- Timing:
  - Each pattern takes SETTLE+1 cycles.
  - With start sampled at edge E0, done rises at edge E(2**N_IN*(SETTLE+1)). Defaults: E12.
- done clears on the edge after it rises, unless it is reset earlier.
- start while busy=1 is ignored; no restart and no queuing.
- start asserted on the same edge that done rises is also ignored, because that edge still belongs to CAPTURE. Accepted from the next edge.
- start held high continuously: a new sweep begins on the first IDLE edge after done.
- expected may change while busy; the latched copy is used.
- Reset mid-sweep: immediate return to reset values; no done pulse; the next start performs a full sweep.
- Width rules:
  - drv wraps only by returning to IDLE; it never increments past all-ones.
  - mism is N_IN+1 bits, so a full mismatch of 2**N_IN entries cannot overflow.

Test Plan:
- AND gate, expected=4'b1000, start pulse at E0 -> drv sequence 00,01,10,11 with 3 cycles each; done at E12; tt=1000; mism=0; pass=1; busy low after E12.
- OR gate, expected=4'b1110 -> tt=1110, pass=1. Combined AND&OR network with expected=4'b1000 -> tt=1000, pass=1.
- gate_out tied 0, expected=4'b1110 -> tt=0000, mism=3, pass=0, done at E12.
- start re-pulsed at E5 mid-sweep and expected changed to 4'b0000 at E4 -> sweep unaffected; single done at E12; result checked against the original 4'b1000.
- rst pulsed at E7 -> drv=0, busy=0, tt=0, no done. New start at E9 -> done at E21 with correct tt.
- SETTLE=1 with an OR gate -> 2 cycles per pattern; done at E8; tt=1110; pass=1.
